// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types, default geometry and configuration check for the fetch queue
package ifq_pkg;
  localparam int ADDR_W = 16;
  localparam int FETCH_BYTES = 3;
  localparam int MAX_LEN = 3;
  localparam int DEPTH = 8;
  localparam logic [ADDR_W-1:0] RESET_ADDR = '0;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int PTR_W = $clog2(DEPTH);
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [7:0] byte_t;
  function automatic bit cfg_ok(input int depth, input int fetch, input int max_len);
    return depth > 0 && (depth & (depth - 1)) == 0 && depth >= fetch + max_len && max_len >= 1;
  endfunction
endpackage

// File: rtl/ifq_if.sv
// ifq_if: memory request/response, redirect and decoder window signals of the fetch queue
// master = queue side (drives req/req_addr/avail/win/head_pc/accept), slave = memory + decoder side
interface ifq_if #(
  parameter int ADDR_W = ifq_pkg::ADDR_W,
  parameter int FETCH_BYTES = ifq_pkg::FETCH_BYTES,
  parameter int MAX_LEN = ifq_pkg::MAX_LEN,
  parameter int DEPTH = ifq_pkg::DEPTH
) ();
  logic redir;
  logic [ADDR_W-1:0] redir_addr;
  logic req;
  logic [ADDR_W-1:0] req_addr;
  logic gnt;
  logic rvalid;
  logic [FETCH_BYTES*8-1:0] rdata;
  logic [$clog2(DEPTH+1)-1:0] avail;
  logic [MAX_LEN*8-1:0] win;
  logic [ADDR_W-1:0] head_pc;
  logic take;
  logic [$clog2(MAX_LEN+1)-1:0] take_len;
  logic accept;
  modport master (
    input redir, redir_addr, gnt, rvalid, rdata, take, take_len,
    output req, req_addr, avail, win, head_pc, accept
  );
  modport slave (
    output redir, redir_addr, gnt, rvalid, rdata, take, take_len,
    input req, req_addr, avail, win, head_pc, accept
  );
endinterface

// File: rtl/ifq_ring.sv
// ifq_ring: byte ring with a FETCH_BYTES-wide write at wr and a MAX_LEN-wide read window at rd
// ports: we/wdata write a beat, adv/adv_len advance rd, flush snaps rd to wr, win is the head window
module ifq_ring import ifq_pkg::*; #(
  parameter int FETCH_BYTES = ifq_pkg::FETCH_BYTES,
  parameter int MAX_LEN = ifq_pkg::MAX_LEN,
  parameter int DEPTH = ifq_pkg::DEPTH,
  parameter int LW = $clog2(MAX_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [FETCH_BYTES*8-1:0] wdata,
  input  logic adv,
  input  logic [LW-1:0] adv_len,
  input  logic flush,
  output logic [MAX_LEN*8-1:0] win
);
  localparam int PW = $clog2(DEPTH);
  byte_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd <= '0;
      wr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (we) begin
        for (int i = 0; i < FETCH_BYTES; i++) mem[wr + PW'(i)] <= wdata[i*8 +: 8];
        wr <= wr + PW'(FETCH_BYTES);
      end
      rd <= flush ? wr : adv ? rd + PW'(adv_len) : rd;
    end
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_win
    assign win[i*8 +: 8] = mem[rd + PW'(i)];
  end
endmodule

// File: rtl/ifq.sv
// ifq: instruction fetch queue -- request control, occupancy, head/fetch addressing and redirect
// ports: clk, rst (async active-low), bus (ifq_if.master: memory handshake, redirect, decoder window)
module ifq import ifq_pkg::*; #(
  parameter int ADDR_W = ifq_pkg::ADDR_W,
  parameter int FETCH_BYTES = ifq_pkg::FETCH_BYTES,
  parameter int MAX_LEN = ifq_pkg::MAX_LEN,
  parameter int DEPTH = ifq_pkg::DEPTH,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input logic clk,
  input logic rst,
  ifq_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  if (!cfg_ok(DEPTH, FETCH_BYTES, MAX_LEN)) begin : g_bad_cfg
    $error("ifq: DEPTH must be a power of two >= FETCH_BYTES+MAX_LEN and MAX_LEN >= 1");
  end
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] fetch_addr, head_pc;
  logic pend, discard, we, acc;
  // a beat is written only when it answers the live request and no redirect kills it
  assign we = bus.rvalid && pend && !discard && !bus.redir;
  assign acc = bus.take && !bus.redir && bus.take_len != '0 &&
               32'(bus.take_len) <= 32'(count) && 32'(bus.take_len) <= 32'(MAX_LEN);
  // space is reserved at issue: count can only fall while pend, so req holds until gnt
  assign bus.req = rst && !pend && !bus.redir && (32'(DEPTH) - 32'(count)) >= 32'(FETCH_BYTES);
  assign bus.req_addr = fetch_addr;
  assign bus.avail = count;
  assign bus.head_pc = head_pc;
  assign bus.accept = acc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count <= '0;
      fetch_addr <= RESET_ADDR;
      head_pc <= RESET_ADDR;
      pend <= 1'b0;
      discard <= 1'b0;
    end else if (bus.redir) begin
      count <= '0;
      fetch_addr <= bus.redir_addr;
      head_pc <= bus.redir_addr;
      // an in-flight request whose beat has not arrived yet must have that beat dropped later
      pend <= pend && !bus.rvalid;
      discard <= pend && !bus.rvalid;
    end else begin
      count <= count + (we ? CW'(FETCH_BYTES) : '0) - (acc ? CW'(bus.take_len) : '0);
      if (bus.req && bus.gnt) begin
        pend <= 1'b1;
        fetch_addr <= fetch_addr + ADDR_W'(FETCH_BYTES);
      end else if (bus.rvalid && pend) begin
        pend <= 1'b0;
        discard <= 1'b0;
      end
      if (acc) head_pc <= head_pc + ADDR_W'(bus.take_len);
    end
  ifq_ring #(.FETCH_BYTES(FETCH_BYTES), .MAX_LEN(MAX_LEN), .DEPTH(DEPTH)) u_ring (
    .clk(clk),
    .rst(rst),
    .we(we),
    .wdata(bus.rdata),
    .adv(acc),
    .adv_len(bus.take_len),
    .flush(bus.redir),
    .win(bus.win)
  );
endmodule
